// File: rtl/gpio_serial_cfg_ctrl.sv
// Shifts every pad control word into the two GPIO serial configuration chains after one start pulse.
// A bit-bang override hands the chain pins straight to the bus side and aborts any load in flight.
module gpio_serial_cfg_ctrl #(
   parameter int CFG_W          = 13,
   parameter int PADS_PER_CHAIN = 19,
   parameter int CLK_DIV        = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [4:0]       cfg_sel,
   input  logic [CFG_W-1:0] cfg_data_1,
   input  logic [CFG_W-1:0] cfg_data_2,
   input  logic             bb_en,
   input  logic             bb_clock,
   input  logic             bb_load,
   input  logic             bb_data_1,
   input  logic             bb_data_2,
   output logic             serial_clock,
   output logic             serial_load,
   output logic             serial_data_1,
   output logic             serial_data_2
);

   localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam int PW = $clog2(CLK_DIV) + 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_TOP  = BW'(CFG_W - 1);
   localparam logic [4:0]    WORD_TOP = 5'(PADS_PER_CHAIN - 1);

   typedef enum logic [2:0] {IDLE, LO, HI, LOAD, FIN} state_t;

   state_t        state, next_state;
   logic [PW-1:0] phase;
   logic [BW-1:0] bit_cnt;
   logic [4:0]    word_cnt;
   logic          phase_end;
   logic          fsm_clock, fsm_load, fsm_d1, fsm_d2, busy_d, done_d;

   assign phase_end = (phase == PH_LAST);
   assign cfg_sel   = word_cnt;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= next_state;
   end

   // Any bb_en while a load is running drops straight back to IDLE without a done pulse.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start && !bb_en) next_state = LO;
         LO:   if (bb_en) next_state = IDLE;
               else if (phase_end) next_state = HI;
         HI:   if (bb_en) next_state = IDLE;
               else if (phase_end) next_state = (bit_cnt != '0 || word_cnt != '0) ? LO : LOAD;
         LOAD: if (bb_en) next_state = IDLE;
               else if (phase_end) next_state = FIN;
         FIN:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || next_state == IDLE) begin
         phase    <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else if (state == IDLE) begin
         phase    <= '0;
         bit_cnt  <= BIT_TOP;
         word_cnt <= WORD_TOP;
      end else begin
         phase <= (next_state != state) ? '0 : phase + 1'b1;
         if (state == HI && phase_end) begin
            if (bit_cnt != '0) begin
               bit_cnt <= bit_cnt - 1'b1;
            end else if (word_cnt != '0) begin
               word_cnt <= word_cnt - 1'b1;
               bit_cnt  <= BIT_TOP;
            end
         end
      end
   end

   // Pin values follow the state one cycle later, so data lands before the clock rises.
   always_comb begin
      fsm_clock = 1'b0;
      fsm_load  = 1'b0;
      fsm_d1    = 1'b0;
      fsm_d2    = 1'b0;
      busy_d    = (next_state != IDLE);
      done_d    = (state == FIN);
      case (state)
         LO: begin
            fsm_d1 = cfg_data_1[bit_cnt];
            fsm_d2 = cfg_data_2[bit_cnt];
         end
         HI: begin
            fsm_clock = 1'b1;
            fsm_d1    = serial_data_1;
            fsm_d2    = serial_data_2;
         end
         LOAD:    fsm_load = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         serial_clock  <= 1'b0;
         serial_load   <= 1'b0;
         serial_data_1 <= 1'b0;
         serial_data_2 <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (bb_en) begin
            serial_clock  <= bb_clock;
            serial_load   <= bb_load;
            serial_data_1 <= bb_data_1;
            serial_data_2 <= bb_data_2;
         end else begin
            serial_clock  <= fsm_clock;
            serial_load   <= fsm_load;
            serial_data_1 <= fsm_d1;
            serial_data_2 <= fsm_d2;
         end
      end
   end

endmodule

// File: tb/tb_gpio_serial_cfg_ctrl.sv
// Bench for gpio_serial_cfg_ctrl: two instances (CLK_DIV 2 and 1) driven from a pad table,
// serial streams checked against a bit list built directly from the pad words.
module tb_gpio_serial_cfg_ctrl;

   localparam int CFG_W = 13;
   localparam int PADS  = 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic wb_rst_i = 1'b1, start_a = 1'b0, start_b = 1'b0;
   logic bb_en = 1'b0, bb_clock = 1'b0, bb_load = 1'b0, bb_data_1 = 1'b0, bb_data_2 = 1'b0;
   logic busy_a, done_a, sclk_a, sld_a, sd1_a, sd2_a;
   logic busy_b, done_b, sclk_b, sld_b, sd1_b, sd2_b;
   logic [4:0] sel_a, sel_b;
   logic [CFG_W-1:0] cfg1_a, cfg2_a, cfg1_b, cfg2_b;
   logic [CFG_W-1:0] pad_cfg [0:37];

   always_comb begin
      cfg1_a = '0; cfg2_a = '0; cfg1_b = '0; cfg2_b = '0;
      if (int'(sel_a) < PADS) begin
         cfg1_a = pad_cfg[int'(sel_a)];
         cfg2_a = pad_cfg[37 - int'(sel_a)];
      end
      if (int'(sel_b) < PADS) begin
         cfg1_b = pad_cfg[int'(sel_b)];
         cfg2_b = pad_cfg[37 - int'(sel_b)];
      end
   end

   gpio_serial_cfg_ctrl #(.CFG_W(CFG_W), .PADS_PER_CHAIN(PADS), .CLK_DIV(2)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start_a), .busy(busy_a), .done(done_a),
      .cfg_sel(sel_a), .cfg_data_1(cfg1_a), .cfg_data_2(cfg2_a),
      .bb_en(bb_en), .bb_clock(bb_clock), .bb_load(bb_load), .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
      .serial_clock(sclk_a), .serial_load(sld_a), .serial_data_1(sd1_a), .serial_data_2(sd2_a));

   gpio_serial_cfg_ctrl #(.CFG_W(CFG_W), .PADS_PER_CHAIN(PADS), .CLK_DIV(1)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start_b), .busy(busy_b), .done(done_b),
      .cfg_sel(sel_b), .cfg_data_1(cfg1_b), .cfg_data_2(cfg2_b),
      .bb_en(bb_en), .bb_clock(bb_clock), .bb_load(bb_load), .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
      .serial_clock(sclk_b), .serial_load(sld_b), .serial_data_1(sd1_b), .serial_data_2(sd2_b));

   int total = 0, bad = 0;

   // Observations of the most recent run_load call.
   int edges, done_cnt, done_at, load_cycles, load_pulses, load_start, last_fall, mism, busy_first;
   int busy_at_abort, zero_at_rst;
   bit exp1 [$], exp2 [$], cap1 [$], cap2 [$];

   function automatic int expected_cycles(input int div);
      return 2 * div * CFG_W * PADS + div + 1;
   endfunction

   task automatic set_pattern();
      for (int p = 0; p < PADS; p++) pad_cfg[p] = 13'h1803 + 13'(p);
      for (int p = PADS; p < 38; p++) pad_cfg[p] = 13'h0403 + 13'(p);
   endtask

   task automatic set_random();
      for (int p = 0; p < 38; p++) pad_cfg[p] = 13'($urandom);
   endtask

   // Starts a load on one instance and watches it for `limit` cycles; optional events
   // (second start, bb_en abort, reset pulse) are applied so they are sampled at the given cycle.
   task automatic run_load(input bit use_b, input int limit, input int restart_at,
                           input int abort_at, input int rst_at);
      logic sc, ld, dn, d1, d2, bz, prev_clk, prev_load;
      logic [9:0] all_out;
      exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
      for (int p = PADS - 1; p >= 0; p--)
         for (int b = CFG_W - 1; b >= 0; b--) exp1.push_back(pad_cfg[p][b]);
      for (int p = PADS; p < 38; p++)
         for (int b = CFG_W - 1; b >= 0; b--) exp2.push_back(pad_cfg[p][b]);
      edges = 0; done_cnt = 0; done_at = -1; load_cycles = 0; load_pulses = 0;
      load_start = -1; last_fall = -1; busy_at_abort = -1; zero_at_rst = -1;
      prev_clk = 1'b0; prev_load = 1'b0;
      @(negedge clk);
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      busy_first = use_b ? int'(busy_b) : int'(busy_a);
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         sc = use_b ? sclk_b : sclk_a;
         ld = use_b ? sld_b  : sld_a;
         dn = use_b ? done_b : done_a;
         d1 = use_b ? sd1_b  : sd1_a;
         d2 = use_b ? sd2_b  : sd2_a;
         bz = use_b ? busy_b : busy_a;
         all_out = use_b ? {busy_b, done_b, sel_b, sclk_b, sld_b, sd1_b | sd2_b}
                         : {busy_a, done_a, sel_a, sclk_a, sld_a, sd1_a | sd2_a};
         if (sc && !prev_clk) begin
            edges++;
            cap1.push_back(d1);
            cap2.push_back(d2);
         end
         if (!sc && prev_clk) last_fall = k;
         if (ld) load_cycles++;
         if (ld && !prev_load) begin load_pulses++; load_start = k; end
         if (dn) begin done_cnt++; if (done_at < 0) done_at = k; end
         prev_clk = sc; prev_load = ld;
         if (k == abort_at) busy_at_abort = int'(bz);
         if (k == rst_at) begin zero_at_rst = int'(all_out); wb_rst_i = 1'b0; end
         if (k == restart_at - 1) begin if (use_b) start_b = 1'b1; else start_a = 1'b1; end
         if (k == restart_at) begin start_a = 1'b0; start_b = 1'b0; end
         if (k == abort_at - 1) bb_en = 1'b1;
         if (k == rst_at - 1) wb_rst_i = 1'b1;
      end
      mism = (cap1.size() > exp1.size()) ? cap1.size() - exp1.size() : exp1.size() - cap1.size();
      mism += (cap2.size() > exp2.size()) ? cap2.size() - exp2.size() : exp2.size() - cap2.size();
      for (int i = 0; i < cap1.size() && i < exp1.size(); i++) if (cap1[i] !== exp1[i]) mism++;
      for (int i = 0; i < cap2.size() && i < exp2.size(); i++) if (cap2[i] !== exp2[i]) mism++;
   endtask

   // Shared body for every load expected to run to completion.
   task automatic check_full(input string tag, input int div);
      total++; if (busy_first !== 1) begin bad++; $display("FAIL %s busy_on_start: got %0d want 1", tag, busy_first); end
      total++; if (edges !== CFG_W * PADS) begin bad++; $display("FAIL %s clock_edges: got %0d want %0d", tag, edges, CFG_W * PADS); end
      total++; if (mism !== 0) begin bad++; $display("FAIL %s stream_bits: got %0d wrong bits want 0", tag, mism); end
      total++; if (done_at !== expected_cycles(div)) begin bad++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at, expected_cycles(div)); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt); end
      total++; if (load_pulses !== 1 || load_cycles !== div) begin bad++; $display("FAIL %s load_pulse: got %0d pulses %0d cycles want 1 and %0d", tag, load_pulses, load_cycles, div); end
      total++; if (load_start !== last_fall) begin bad++; $display("FAIL %s load_after_fall: got load at %0d want %0d", tag, load_start, last_fall); end
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy_a, done_a, sel_a, sclk_a, sld_a, sd1_a, sd2_a} !== 11'd0) begin
         bad++; $display("FAIL reset_a: got %b want 0", {busy_a, done_a, sel_a, sclk_a, sld_a, sd1_a, sd2_a});
      end
      total++;
      if ({busy_b, done_b, sel_b, sclk_b, sld_b, sd1_b, sd2_b} !== 11'd0) begin
         bad++; $display("FAIL reset_b: got %b want 0", {busy_b, done_b, sel_b, sclk_b, sld_b, sd1_b, sd2_b});
      end
      wb_rst_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_load();
      set_pattern();
      run_load(1'b0, 1100, -10, -10, -10);
      check_full("full_div2", 2);
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL full_div2 busy_after: got %0d want 0", busy_a); end
   endtask

   task automatic test_restart_ignored();
      run_load(1'b0, 1100, 100, -10, -10);
      check_full("restart", 2);
   endtask

   task automatic test_bitbang();
      bit seq [3] = '{1'b1, 1'b0, 1'b1};
      logic [3:0] v, pv;
      @(negedge clk);
      bb_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bb_clock = seq[i]; bb_data_1 = 1'b1;
         @(negedge clk);
         total++;
         if (sclk_a !== seq[i] || sd1_a !== 1'b1) begin
            bad++; $display("FAIL bb_mirror[%0d]: got clk=%0d d1=%0d want clk=%0d d1=1", i, sclk_a, sd1_a, seq[i]);
         end
      end
      pv = 4'($urandom);
      {bb_clock, bb_load, bb_data_1, bb_data_2} = pv;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         v = {sclk_a, sld_a, sd1_a, sd2_a};
         total++;
         if (v !== pv) begin bad++; $display("FAIL bb_random[%0d]: got %b want %b", i, v, pv); end
         pv = 4'($urandom);
         {bb_clock, bb_load, bb_data_1, bb_data_2} = pv;
      end
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL bb_start_ignored: got busy=%0d done=%0d want 0", busy_a, done_a); end
      {bb_clock, bb_load, bb_data_1, bb_data_2} = 4'd0;
      bb_en = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({sclk_a, sld_a, sd1_a, sd2_a, busy_a} !== 5'd0) begin
         bb_en = 1'b0; bad++; $display("FAIL bb_release: got %b want 0", {sclk_a, sld_a, sd1_a, sd2_a, busy_a});
      end
   endtask

   task automatic test_abort();
      set_random();
      run_load(1'b0, 1100, -10, 300, -10);
      bb_en = 1'b0;
      total++; if (busy_at_abort !== 0) begin bad++; $display("FAIL abort_busy: got %0d want 0", busy_at_abort); end
      total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
      total++; if (load_pulses !== 0) begin bad++; $display("FAIL abort_load: got %0d pulses want 0", load_pulses); end
      @(negedge clk);
      run_load(1'b0, 1100, -10, -10, -10);
      check_full("after_abort", 2);
   endtask

   task automatic test_reset_mid_load();
      set_random();
      run_load(1'b0, 1100, -10, -10, 500);
      total++; if (zero_at_rst !== 0) begin bad++; $display("FAIL midrst_outputs: got %b want 0", zero_at_rst); end
      total++; if (done_cnt !== 0 || load_pulses !== 0) begin bad++; $display("FAIL midrst_no_finish: got done=%0d load=%0d want 0", done_cnt, load_pulses); end
      run_load(1'b0, 1100, -10, -10, -10);
      check_full("after_rst", 2);
   endtask

   task automatic test_div1();
      set_pattern();
      run_load(1'b1, 600, -10, -10, -10);
      check_full("full_div1", 1);
      set_random();
      run_load(1'b1, 600, -10, -10, -10);
      check_full("rand_div1", 1);
   endtask

   task automatic test_random_loads();
      for (int r = 0; r < 2; r++) begin
         set_random();
         run_load(1'b0, 1100, -10, -10, -10);
         check_full("rand_div2", 2);
      end
   endtask

   initial begin
      set_pattern();
      test_reset();
      test_full_load();
      test_restart_ignored();
      test_bitbang();
      test_abort();
      test_reset_mid_load();
      test_div1();
      test_random_loads();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
